lane_generator: RTL and testbench
=================================

# lane_generator

Supplies the per-lane car pattern that the car renderer requests: the renderer drives `car_select` and reads back `car_type` on the same cycle. The block holds an 8-entry lane table, shifts it by one lane whenever the scroll position crosses a lane boundary, and fills the vacated lane with a pseudo-random car type. Sits between the scroll/game-state logic and the renderer in the VGA pipeline.

## Interface
- `NUM_LANES`, 8: table depth; fixed by the 3-bit `car_select`.
- `LANE_BITS`, 6: lane height is 2^LANE_BITS scroll pixels; lane index = `scrolladdr[10:LANE_BITS]`.
- `MAX_RUN`, 3: maximum number of consecutive non-empty lanes generated.
- `FRAME_LINE`, 480: `vaddr` value on which the frame tick fires.
- `SEED`, 16'hACE1: LFSR reset value; must be non-zero.

Ports:
- `clk` in 1: pixel clock; the only clock.
- `sys_rst` in 1: reset, synchronous, active-low.
- `game_over` in 1: level; freezes table updates.
- `game_start` in 1: single-cycle pulse; reinitialises the table.
- `car_select` in 3: lane index requested by the renderer.
- `vaddr` in 10, `haddr` in 10: current raster position.
- `scrolladdr` in 11: current vertical scroll offset.
- `car_type` out 3: `table[car_select]`; 0 = empty lane, 1–7 = car patterns.
- `lane_shift` out 1: single-cycle pulse on each table shift.
- `lanes_passed` out 8: count of shifts since reset/start; saturates at 255.

## Operation
- `car_type` is a combinational read of the registered table. No handshake; valid whenever `car_select` is stable.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every cycle while `sys_rst` is high, including during `game_over`. It is not reseeded by `game_start`.
- Frame tick: single cycle where `vaddr == FRAME_LINE && haddr == 0`. The table changes only on a frame tick, so the renderer never sees a mid-frame change.
- State `last_lane` (11−LANE_BITS bits):
  - On a frame tick with `game_over` low and `last_lane != scrolladdr[10:LANE_BITS]`: shift `table[i] <= table[i-1]` for i = 7..1; `table[0] <= new_type`; `last_lane <= last_lane + 1` (modulo, wraps 31→0); pulse `lane_shift`; increment `lanes_passed` (saturating).
  - At most one shift per frame. A jump of N lanes catches up over N frames.
- Type generation:
  - `new_type = lfsr[2:0]`.
  - If `run_cnt == MAX_RUN`, force `new_type = 0`.
  - `run_cnt` resets to 0 when a 0 is inserted, otherwise increments by 1.
- `game_start` (any cycle, priority over a coincident frame tick): table ← all 0, `run_cnt` ← 0, `lanes_passed` ← 0, `last_lane` ← current `scrolladdr[10:LANE_BITS]`; no `lane_shift` pulse.
- `game_over` high: no shifts, and `last_lane` is held. After `game_over` falls, pending lanes catch up one per frame.

## Timing
- Reset values (the cycle after `sys_rst` is sampled low): table all 0, `car_type` 0, `lane_shift` 0, `lanes_passed` 0, `run_cnt` 0, `last_lane` 0, LFSR = `SEED`.
- `car_type` has 0-cycle latency from `car_select`, and 1-cycle latency from the frame tick to the new table contents.
- `lane_shift` is high for exactly the cycle after the shifting frame tick.
- Reset asserted mid-operation overrides everything on the next edge, including a `game_start` or a frame tick in the same cycle.

## Structure
- Shared package `crossy_pkg` holds:
  - car type constants (`CAR_NONE` = 3'd0), `LANE_BITS`, `FRAME_LINE`;
  - LFSR seed and tap constants, also used by other random sources.
- Sub-module `lfsr16`: enable, seed parameter, 16-bit state output.
- The table is 8×3 flops; no RAM.

## Test plan
- Reset, then sweep `car_select` 0..7 → `car_type` = 0 for every lane; `lanes_passed` = 0; LFSR = 16'hACE1.
- Step `scrolladdr` 0→64, hold to the frame tick → exactly one `lane_shift` pulse, `table[1..7]` shifted, `table[0]` = LFSR[2:0] sampled at the tick, `lanes_passed` = 1.
- Force an LFSR sequence yielding non-zero types for 4 lanes → lane 4 inserted as 0; `run_cnt` returns to 0.
- Jump `scrolladdr` 0→320 (5 lanes) → one shift per frame over 5 frames, then none. Wrap test: `scrolladdr` 1984→0 → one shift (`last_lane` 31→0).
- With `game_over` high across 3 boundary crossings → no shifts and table stable. Release `game_over` → 3 shifts over 3 frames.
- Assert `game_start` on the same cycle as a qualifying frame tick → table all 0, no `lane_shift`, `last_lane` = current scroll lane, `lanes_passed` = 0.

Source files
------------

// File: rtl/crossy_pkg.sv
// Shared constants for the crossy game pipeline: car types, lane geometry,
// frame timing and the LFSR seed/taps reused by every random source.
package crossy_pkg;

  typedef logic [2:0] car_type_t;

  localparam car_type_t CAR_NONE   = 3'd0;

  localparam int          LANE_BITS  = 6;
  localparam int          MAX_RUN    = 3;
  localparam logic [9:0]  FRAME_LINE = 10'd480;

  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_SEED  = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS  = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] state,
                                            input logic [15:0] taps);
    return {state[14:0], ^(state & taps)};
  endfunction

endpackage

// File: rtl/lane_generator_if.sv
// Renderer / game-state bus of the lane generator. The slave modport is the
// generator; the master modport is whoever drives raster, scroll and select.
interface lane_generator_if;
  import crossy_pkg::*;

  logic        game_over;
  logic        game_start;
  logic [2:0]  car_select;
  logic [9:0]  vaddr;
  logic [9:0]  haddr;
  logic [10:0] scrolladdr;
  car_type_t   car_type;
  logic        lane_shift;
  logic [7:0]  lanes_passed;

  modport slave (
    input  game_over,
    input  game_start,
    input  car_select,
    input  vaddr,
    input  haddr,
    input  scrolladdr,
    output car_type,
    output lane_shift,
    output lanes_passed
  );

  modport master (
    output game_over,
    output game_start,
    output car_select,
    output vaddr,
    output haddr,
    output scrolladdr,
    input  car_type,
    input  lane_shift,
    input  lanes_passed
  );

endinterface

// File: rtl/lane_generator_lfsr16.sv
// 16-bit Fibonacci LFSR with enable; reloads SEED on synchronous reset.
// SEED must be non-zero or the register locks up at all-zeros.
module lfsr16
  import crossy_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED
) (
  input  logic        clk,
  input  logic        sys_rst,
  input  logic        en_i,
  output logic [15:0] state_o
);

  logic [15:0] state_q;
  logic [15:0] state_d;

  always_comb begin
    state_d = state_q;
    if (en_i) begin
      state_d = lfsr_next(state_q, LFSR_TAPS);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: registers take non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    if (!sys_rst) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/lane_generator.sv
// Lane table for the car renderer: shifts one lane per frame tick while the
// scroll position is ahead of the table, filling lane 0 with a random car type.
module lane_generator
  import crossy_pkg::car_type_t;
  import crossy_pkg::CAR_NONE;
  import crossy_pkg::LFSR_SEED;
#(
  parameter int          NUM_LANES  = 8,
  parameter int          LANE_BITS  = crossy_pkg::LANE_BITS,
  parameter int          MAX_RUN    = crossy_pkg::MAX_RUN,
  parameter logic [9:0]  FRAME_LINE = crossy_pkg::FRAME_LINE,
  parameter logic [15:0] SEED       = LFSR_SEED
) (
  input  logic             clk,
  input  logic             sys_rst,
  lane_generator_if.slave  bus
);

  localparam int               LANE_W    = 11 - LANE_BITS;
  localparam int               RUN_W     = $clog2(MAX_RUN + 1);
  localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(MAX_RUN);

  car_type_t          lane_tbl_q [NUM_LANES];
  car_type_t          lane_tbl_d [NUM_LANES];
  logic [LANE_W-1:0]  last_lane_q;
  logic [LANE_W-1:0]  last_lane_d;
  logic [RUN_W-1:0]   run_cnt_q;
  logic [RUN_W-1:0]   run_cnt_d;
  logic [7:0]         passed_q;
  logic [7:0]         passed_d;
  logic               lane_shift_q;
  logic               lane_shift_d;

  logic [15:0]        lfsr_state;
  logic [LANE_W-1:0]  scroll_lane;
  logic               frame_tick;
  logic               shift_en;
  car_type_t          new_type;

  logic               unused_lfsr;
  logic               unused_scroll;

  // The LFSR free-runs out of reset; game_start deliberately does not reseed it.
  lfsr16 #(
    .SEED (SEED)
  ) u_lfsr (
    .clk     (clk),
    .sys_rst (sys_rst),
    .en_i    (1'b1),
    .state_o (lfsr_state)
  );

  assign unused_lfsr   = ^lfsr_state[15:3];
  assign unused_scroll = ^bus.scrolladdr[LANE_BITS-1:0];

  assign scroll_lane = bus.scrolladdr[10:LANE_BITS];
  assign frame_tick  = (bus.vaddr == FRAME_LINE) && (bus.haddr == '0);
  assign shift_en    = frame_tick && !bus.game_over && (last_lane_q != scroll_lane);
  assign new_type    = (run_cnt_q == RUN_LIMIT) ? CAR_NONE : car_type_t'(lfsr_state[2:0]);

  always_comb begin
    // NOTE: every next-state signal gets its hold value first, so no path
    // through the branches below can leave one unassigned and infer a latch.
    lane_tbl_d   = lane_tbl_q;
    last_lane_d  = last_lane_q;
    run_cnt_d    = run_cnt_q;
    passed_d     = passed_q;
    lane_shift_d = 1'b0;

    if (bus.game_start) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        lane_tbl_d[i] = CAR_NONE;
      end
      run_cnt_d   = '0;
      passed_d    = '0;
      last_lane_d = scroll_lane;
    end else if (shift_en) begin
      for (int i = NUM_LANES - 1; i > 0; i--) begin
        lane_tbl_d[i] = lane_tbl_q[i-1];
      end
      lane_tbl_d[0] = new_type;
      run_cnt_d     = (new_type == CAR_NONE) ? '0 : run_cnt_q + 1'b1;
      last_lane_d   = last_lane_q + 1'b1;
      passed_d      = (passed_q == 8'hFF) ? passed_q : passed_q + 8'd1;
      lane_shift_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!sys_rst) begin
      // NOTE: the table is a handful of flops rather than a RAM, so it is
      // cleared on reset like any other state.
      for (int i = 0; i < NUM_LANES; i++) begin
        lane_tbl_q[i] <= CAR_NONE;
      end
      last_lane_q  <= '0;
      run_cnt_q    <= '0;
      passed_q     <= '0;
      lane_shift_q <= 1'b0;
    end else begin
      lane_tbl_q   <= lane_tbl_d;
      last_lane_q  <= last_lane_d;
      run_cnt_q    <= run_cnt_d;
      passed_q     <= passed_d;
      lane_shift_q <= lane_shift_d;
    end
  end

  assign bus.car_type     = lane_tbl_q[bus.car_select];
  assign bus.lane_shift   = lane_shift_q;
  assign bus.lanes_passed = passed_q;

endmodule

// File: tb/tb_lane_generator.sv
// Scoreboarded bench for lane_generator: a lane-queue reference model predicts
// each table shift, and a monitor compares the whole table on every lane_shift.
module tb_lane_generator;

  typedef struct packed {
    logic [7:0]      passed;
    logic [7:0][2:0] tbl;
  } snap_t;

  logic clk = 1'b0;
  logic sys_rst = 1'b0;
  always #10 clk = ~clk;

  lane_generator_if bus ();

  lane_generator dut (
    .clk     (clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  snap_t shift_q[$];
  snap_t snap_q[$];

  // Reference model state: lane 0 is the front of the queue.
  int m_tbl[$];
  int m_lfsr;
  int m_run;
  int m_last;
  int m_passed;
  int m_lane_now;
  int m_type;

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int lfsr_step(input int s);
    int fb;
    fb = ((s >> 15) ^ (s >> 13) ^ (s >> 12) ^ (s >> 10)) & 1;
    return ((s << 1) | fb) & 'hFFFF;
  endfunction

  function automatic snap_t model_snapshot();
    snap_t s;
    for (int i = 0; i < 8; i++) s.tbl[i] = 3'(m_tbl[i]);
    s.passed = 8'(m_passed);
    return s;
  endfunction

  task automatic clear_table();
    m_tbl.delete();
    repeat (8) m_tbl.push_back(0);
  endtask

  // Reference model: evaluated on each rising edge from the inputs held there.
  initial begin
    clear_table();
    forever begin
      @(posedge clk);
      if (!sys_rst) begin
        clear_table();
        m_lfsr = 'hACE1; m_run = 0; m_last = 0; m_passed = 0;
      end else begin
        m_lane_now = int'(bus.scrolladdr) / 64;
        if (bus.game_start) begin
          clear_table();
          m_run = 0; m_passed = 0; m_last = m_lane_now;
        end else if (bus.vaddr == 10'd480 && bus.haddr == 10'd0 &&
                     !bus.game_over && m_last != m_lane_now) begin
          m_type = (m_run == 3) ? 0 : (m_lfsr & 7);
          m_tbl.push_front(m_type);
          void'(m_tbl.pop_back());
          m_run    = (m_type == 0) ? 0 : m_run + 1;
          m_last   = (m_last + 1) % 32;
          m_passed = (m_passed < 255) ? m_passed + 1 : 255;
          shift_q.push_back(model_snapshot());
        end
        m_lfsr = lfsr_step(m_lfsr);
      end
    end
  end

  task automatic compare_state(input string tag, input snap_t exp);
    for (int i = 0; i < 8; i++) begin
      bus.car_select = 3'(i);
      #1;
      check($sformatf("%s car_type[%0d]", tag, i), int'(bus.car_type), int'(exp.tbl[i]));
    end
    check({tag, " lanes_passed"}, int'(bus.lanes_passed), int'(exp.passed));
  endtask

  // Monitor: owns car_select and sweeps all lanes within the low clock phase.
  initial begin
    snap_t exp;
    bus.car_select = 3'd0;
    forever begin
      @(negedge clk);
      if (bus.lane_shift === 1'b1) begin
        if (shift_q.size() == 0) begin
          check("lane_shift without expected shift", int'(bus.lane_shift), 0);
        end else begin
          exp = shift_q.pop_front();
          compare_state("shift", exp);
        end
      end else if (snap_q.size() != 0) begin
        exp = snap_q.pop_front();
        compare_state("snapshot", exp);
      end
    end
  end

  task automatic drive_idle();
    bus.game_start = 1'b0;
    bus.vaddr      = 10'($urandom_range(0, 523));
    bus.haddr      = (bus.vaddr == 10'd480) ? 10'($urandom_range(1, 799))
                                            : 10'($urandom_range(0, 799));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      drive_idle();
    end
  endtask

  task automatic frame();
    @(negedge clk);
    bus.game_start = 1'b0;
    bus.vaddr      = 10'd480;
    bus.haddr      = 10'd0;
    idle(3);
  endtask

  task automatic start_game();
    @(negedge clk);
    drive_idle();
    bus.game_start = 1'b1;
    idle(2);
  endtask

  task automatic snap();
    @(negedge clk);
    drive_idle();
    snap_q.push_back(model_snapshot());
    idle(3);
  endtask

  initial begin
    bus.game_over  = 1'b0;
    bus.game_start = 1'b0;
    bus.scrolladdr = 11'd0;
    bus.vaddr      = 10'd0;
    bus.haddr      = 10'd0;

    // Reset, then whole-table sweep.
    idle(3);
    @(negedge clk);
    sys_rst = 1'b1;
    drive_idle();
    check("reset lane_shift", int'(bus.lane_shift), 0);
    check("reset lanes_passed", int'(bus.lanes_passed), 0);
    snap();

    // Within-lane scroll does not shift; crossing into lane 1 shifts once.
    bus.scrolladdr = 11'd63;
    frame();
    bus.scrolladdr = 11'd64;
    frame();
    frame();
    snap();

    // Five-lane jump catches up one lane per frame.
    bus.scrolladdr = 11'd0;
    start_game();
    bus.scrolladdr = 11'd320;
    repeat (7) frame();

    // Wrap from lane 31 to lane 0.
    bus.scrolladdr = 11'd1984;
    start_game();
    bus.scrolladdr = 11'd0;
    frame();
    frame();
    snap();

    // game_over freezes the table across three crossings; release catches up.
    bus.scrolladdr = 11'd0;
    start_game();
    bus.scrolladdr = 11'd128;
    frame();
    frame();
    bus.game_over = 1'b1;
    for (int j = 3; j <= 5; j++) begin
      bus.scrolladdr = 11'(j * 64);
      frame();
    end
    snap();
    bus.game_over = 1'b0;
    repeat (4) frame();
    snap();

    // game_start coincident with a qualifying frame tick wins.
    bus.scrolladdr = 11'd448;
    @(negedge clk);
    bus.vaddr      = 10'd480;
    bus.haddr      = 10'd0;
    bus.game_start = 1'b1;
    idle(3);
    snap();
    frame();

    // Reset mid-operation overrides a coincident game_start and frame tick.
    bus.scrolladdr = 11'd512;
    @(negedge clk);
    sys_rst        = 1'b0;
    bus.vaddr      = 10'd480;
    bus.haddr      = 10'd0;
    bus.game_start = 1'b1;
    @(negedge clk);
    drive_idle();
    sys_rst = 1'b1;
    idle(2);
    snap();
    frame();

    // Long advance: run-length limit and lanes_passed saturation.
    bus.scrolladdr = 11'd0;
    start_game();
    for (int k = 1; k <= 270; k++) begin
      bus.scrolladdr = 11'(k * 64);
      frame();
    end
    snap();

    // Randomised mix of scroll steps, game_over and restarts.
    for (int k = 0; k < 200; k++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 4) start_game();
      else if (r < 12) bus.game_over = ~bus.game_over;
      else if (r < 16) bus.scrolladdr = 11'($urandom_range(0, 2047));
      else bus.scrolladdr = 11'(int'(bus.scrolladdr) + $urandom_range(0, 100));
      frame();
    end
    bus.game_over = 1'b0;
    repeat (4) frame();
    snap();

    idle(5);
    @(posedge clk);
    check("pending expected shifts", shift_q.size(), 0);
    check("pending snapshots", snap_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
